// File: rtl/branch_resolve_unit.sv
// Two-stage conditional-branch resolution stage with valid/ready handshakes.
// Operands are biased in S1 so that one unsigned cascaded comparator serves every compare type.

module cascade_comparator #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         gt,
    output logic         lt,
    output logic         eq
);
    // N must be a multiple of 4. Nibbles are scanned from the MSB down, and the first unequal nibble decides.
    localparam int NIBBLES = N / 4;

    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        eq = 1'b1;
        for (int i = NIBBLES - 1; i >= 0; i--) begin
            if (eq) begin
                if (a[i*4 +: 4] > b[i*4 +: 4]) begin
                    gt = 1'b1;
                    eq = 1'b0;
                end else if (a[i*4 +: 4] < b[i*4 +: 4]) begin
                    lt = 1'b1;
                    eq = 1'b0;
                end
            end
        end
    end
endmodule

module branch_resolve_unit #(
    parameter int XLEN       = 64,
    parameter int ILEN_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_redirect_pc,
    output logic            out_mispredict,
    output logic            out_misaligned,
    output logic            out_illegal
);
    logic            s1_valid;
    logic [2:0]      s1_funct3;
    logic            s1_pred_taken;
    logic [XLEN-1:0] s1_op_a;
    logic [XLEN-1:0] s1_op_b;
    logic [XLEN-1:0] s1_target;
    logic [XLEN-1:0] s1_fallthrough;

    logic            s2_valid;
    logic            s2_taken;
    logic [XLEN-1:0] s2_target;
    logic [XLEN-1:0] s2_redirect_pc;
    logic            s2_mispredict;
    logic            s2_misaligned;
    logic            s2_illegal;

    logic            s2_load;
    logic            in_signed;
    logic [XLEN-1:0] sign_flip;
    logic            cmp_gt;
    logic            cmp_lt;
    logic            cmp_eq;
    logic            cond;
    logic            illegal;
    logic            taken;

    assign s2_load   = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_load;
    assign in_signed = (in_funct3[2:1] == 2'b10);
    assign sign_flip = {in_signed, {(XLEN-1){1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_funct3      <= '0;
            s1_pred_taken  <= 1'b0;
            s1_op_a        <= '0;
            s1_op_b        <= '0;
            s1_target      <= '0;
            s1_fallthrough <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_funct3      <= in_funct3;
                s1_pred_taken  <= in_pred_taken;
                s1_op_a        <= in_rs1 ^ sign_flip;
                s1_op_b        <= in_rs2 ^ sign_flip;
                s1_target      <= in_pc + in_imm;
                s1_fallthrough <= in_pc + XLEN'(ILEN_BYTES);
            end
        end
    end

    cascade_comparator #(.N(XLEN)) u_cmp (
        .a  (s1_op_a),
        .b  (s1_op_b),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

    // The biased operands let signed and unsigned compares share the same lt/gt flags.
    always_comb begin
        illegal = (s1_funct3[2:1] == 2'b01);
        cond    = 1'b0;
        case (s1_funct3)
            3'b000:  cond = cmp_eq;
            3'b001:  cond = ~cmp_eq;
            3'b100:  cond = cmp_lt;
            3'b101:  cond = cmp_gt | cmp_eq;
            3'b110:  cond = cmp_lt;
            3'b111:  cond = cmp_gt | cmp_eq;
            default: cond = 1'b0;
        endcase
        taken = cond & ~illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            s2_taken       <= 1'b0;
            s2_target      <= '0;
            s2_redirect_pc <= '0;
            s2_mispredict  <= 1'b0;
            s2_misaligned  <= 1'b0;
            s2_illegal     <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_taken       <= taken;
                s2_target      <= s1_target;
                s2_redirect_pc <= taken ? s1_target : s1_fallthrough;
                s2_mispredict  <= ~illegal & (taken != s1_pred_taken);
                s2_misaligned  <= taken & (s1_target[1:0] != 2'b00);
                s2_illegal     <= illegal;
            end
        end
    end

    assign out_valid       = s2_valid;
    assign out_taken       = s2_taken;
    assign out_target      = s2_target;
    assign out_redirect_pc = s2_redirect_pc;
    assign out_mispredict  = s2_mispredict;
    assign out_misaligned  = s2_misaligned;
    assign out_illegal     = s2_illegal;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + random bench for branch_resolve_unit.
// Each expected result is queued when the branch is accepted and compared when the branch leaves the unit.

module tb_branch_resolve_unit;
    localparam int XLEN = 64;

    typedef struct {
        logic            taken;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] redirect;
        logic            mispredict;
        logic            misaligned;
        logic            illegal;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_funct3 = '0;
    logic [XLEN-1:0] in_rs1 = '0;
    logic [XLEN-1:0] in_rs2 = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_imm = '0;
    logic            in_pred_taken = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_redirect_pc;
    logic            out_mispredict;
    logic            out_misaligned;
    logic            out_illegal;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    branch_resolve_unit #(.XLEN(XLEN), .ILEN_BYTES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_funct3       (in_funct3),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_pc           (in_pc),
        .in_imm          (in_imm),
        .in_pred_taken   (in_pred_taken),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_taken       (out_taken),
        .out_target      (out_target),
        .out_redirect_pc (out_redirect_pc),
        .out_mispredict  (out_mispredict),
        .out_misaligned  (out_misaligned),
        .out_illegal     (out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm, input logic pred);
        exp_t e;
        logic c;
        logic [XLEN-1:0] fall;
        e.target  = pc + imm;
        fall      = pc + 64'd4;
        e.illegal = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'b000:  c = (a == b);
            3'b001:  c = (a != b);
            3'b100:  c = ($signed(a) < $signed(b));
            3'b101:  c = ($signed(a) >= $signed(b));
            3'b110:  c = (a < b);
            3'b111:  c = (a >= b);
            default: c = 1'b0;
        endcase
        e.taken      = c && !e.illegal;
        e.redirect   = e.taken ? e.target : fall;
        e.mispredict = e.illegal ? 1'b0 : (e.taken != pred);
        e.misaligned = e.taken && (e.target[1:0] != 2'b00);
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [XLEN-1:0] observed, input logic [XLEN-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkValue("taken",      64'(out_taken),      64'(e.taken));
        checkValue("target",     out_target,          e.target);
        checkValue("redirect",   out_redirect_pc,     e.redirect);
        checkValue("mispredict", 64'(out_mispredict), 64'(e.mispredict));
        checkValue("misaligned", 64'(out_misaligned), 64'(e.misaligned));
        checkValue("illegal",    64'(out_illegal),    64'(e.illegal));
    endtask

    // Scoreboard: pop on output handshake, wipe on flush, push on input handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checkValue("unexpected_out", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) checkOutput(sb.pop_front());
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready)
                sb.push_back(model(in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken));
        end
    end

    task automatic driveInputs(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm, input logic pred);
        in_funct3     = f3;
        in_rs1        = a;
        in_rs2        = b;
        in_pc         = pc;
        in_imm        = imm;
        in_pred_taken = pred;
        in_valid      = 1'b1;
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm, input logic pred);
        int n = 0;
        driveInputs(f3, a, b, pc, imm, pred);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkValue("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        $display("[TB] start");
        #1;
        @(negedge clk);
        checkValue("rst_out_valid", 64'(out_valid), 64'd0);
        checkValue("rst_in_ready",  64'(in_ready),  64'd1);
        checkValue("rst_taken",     64'(out_taken), 64'd0);
        checkValue("rst_target",    out_target,     64'd0);
        checkValue("rst_redirect",  out_redirect_pc, 64'd0);
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(1);

        // BEQ taken with a two-cycle latency
        applyStimulus(3'b000, 64'h1234, 64'h1234, 64'h1000, 64'h40, 1'b0);
        @(negedge clk);
        checkValue("lat_stage1", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkValue("lat_stage2", 64'(out_valid), 64'd1);
        checkValue("beq_target", out_target, 64'h1040);
        checkValue("beq_mispredict", 64'(out_mispredict), 64'd1);
        @(posedge clk);
        #1;
        idleCycles(2);

        // Signed and unsigned compares
        applyStimulus(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h2000, 64'h10, 1'b1);
        applyStimulus(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h2004, 64'h10, 1'b1);
        applyStimulus(3'b101, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h2008, 64'h20, 1'b0);
        applyStimulus(3'b111, 64'd5, 64'd9, 64'h200C, 64'h20, 1'b0);
        applyStimulus(3'b001, 64'd7, 64'd7, 64'h2010, 64'h20, 1'b1);

        // Wrap-around of target and fall-through
        applyStimulus(3'b001, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b1);
        applyStimulus(3'b000, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b0);

        // Illegal funct3 and a misaligned target
        applyStimulus(3'b010, 64'd3, 64'd3, 64'h3000, 64'h40, 1'b1);
        applyStimulus(3'b011, 64'd3, 64'd4, 64'h3000, 64'h40, 1'b0);
        applyStimulus(3'b000, 64'd9, 64'd9, 64'h3000, 64'h2, 1'b1);
        idleCycles(4);

        // Backpressure: two entries fill the pipe, then in_ready must hold low
        out_ready = 1'b0;
        applyStimulus(3'b000, 64'd0, 64'd0, 64'h4000, 64'h100, 1'b1);
        applyStimulus(3'b001, 64'd0, 64'd1, 64'h4004, 64'h100, 1'b0);
        driveInputs(3'b100, 64'd2, 64'd3, 64'h4008, 64'h100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkValue("bp_in_ready", 64'(in_ready), 64'd0);
            checkValue("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 2; i < 8; i++)
            applyStimulus(3'(i), 64'(i), 64'(7 - i), 64'h4000 + 64'(4 * i), 64'h100, i[0]);
        idleCycles(4);
        checkValue("bp_drained", 64'(sb.size()), 64'd0);

        // Flush with two entries in flight plus a new request
        out_ready = 1'b0;
        applyStimulus(3'b000, 64'd1, 64'd1, 64'h5000, 64'h10, 1'b0);
        applyStimulus(3'b000, 64'd1, 64'd1, 64'h5004, 64'h10, 1'b0);
        driveInputs(3'b000, 64'd1, 64'd1, 64'h5008, 64'h10, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkValue("flush_out_valid", 64'(out_valid), 64'd0);
        checkValue("flush_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        idleCycles(4);

        // Flush discards a handshake into an empty pipe
        driveInputs(3'b000, 64'd2, 64'd2, 64'h6000, 64'h10, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        idleCycles(4);
        checkValue("flush_discard", 64'(out_valid), 64'd0);

        // Reset mid-operation
        out_ready = 1'b0;
        applyStimulus(3'b000, 64'd4, 64'd4, 64'h7000, 64'h10, 1'b0);
        applyStimulus(3'b000, 64'd4, 64'd4, 64'h7004, 64'h10, 1'b0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        @(negedge clk);
        checkValue("midrst_out_valid", 64'(out_valid), 64'd0);
        checkValue("midrst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idleCycles(3);
        checkValue("midrst_quiet", 64'(out_valid), 64'd0);

        // Random back-to-back stream
        for (int i = 0; i < 24; i++) begin
            logic [2:0] f3;
            logic [XLEN-1:0] a;
            logic [XLEN-1:0] b;
            f3 = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            b  = (i % 3 == 0) ? a : {$urandom, $urandom};
            applyStimulus(f3, a, b, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        end

        begin
            int n = 0;
            while (sb.size() > 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        checkValue("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
